// File: rtl/vmem_arbiter.sv
// Round-robin arbiter sharing one virtual_mem request port between fetch (0) and load/store (1).
// Optional WAIT watchdog enabled by defining VMEM_ARB_TIMEOUT_EN.
module vmem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_address0,
    input  logic [ADDR_W-1:0] req_address1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ack,
    output logic [1:0]        req_done,
    output logic [1:0]        req_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_valid,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_grant;
    logic              r_last_grant;
    logic              r_err;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              w_sel;
    logic              w_latch;
    logic              w_finish;
    logic              w_timeout;

    // A tie goes to the port that was not served last.
    assign w_sel    = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
    assign w_latch  = (r_state == S_IDLE) && (|req_valid);
    assign w_finish = (r_state == S_WAIT) && (mem_ready || w_timeout);

`ifdef VMEM_ARB_TIMEOUT_EN
    logic [15:0] r_wait_cnt;

    // Expiry only when ready is absent; a same-cycle ready completes normally.
    assign w_timeout = (r_state == S_WAIT) && !mem_ready &&
                       (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_WAIT) && !mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ack   = '0;
        req_done  = '0;
        req_err   = '0;
        mem_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_latch) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_valid        = 1'b1;
                req_ack[r_grant] = 1'b1;
                w_next           = S_WAIT;
            end
            S_WAIT: begin
                if (w_finish) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                req_done[r_grant] = 1'b1;
                req_err[r_grant]  = r_err;
                w_next            = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_err         <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_rsp_rdata   <= '0;
        end else begin
            if (w_latch) begin
                r_grant       <= w_sel;
                r_mem_write   <= req_write[w_sel];
                r_mem_address <= w_sel ? req_address1 : req_address0;
                r_mem_wdata   <= w_sel ? req_wdata1 : req_wdata0;
            end
            if (w_finish) begin
                r_last_grant <= r_grant;
                r_err        <= w_timeout;
                r_rsp_rdata  <= w_timeout ? '0 : mem_rdata;
            end
        end
    end

    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign rsp_rdata   = r_rsp_rdata;
    assign busy        = (r_state != S_IDLE);

endmodule
